// File: rtl/spi_rom_reader.sv
// SPI mode-0 master that fetches one byte from an address-indexed SPI ROM slave.
// A frame sends an 8-bit address MSB first and then clocks 8 more SCLK periods.
// The byte returned on MISO during those 8 periods is captured into rd_data.
// All pin outputs come straight from flops, so they cannot glitch.
module spi_rom_reader #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] addr,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       sclk,
    output logic       cs_n,
    output logic       mosi,
    input  logic       miso
);

    localparam int               DIV_W    = $clog2(CLK_DIV) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StFinish
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       bit_cnt;
    logic [7:0]       tx_sr;
    logic [7:0]       rx_sr;

    // Frame sequencer: every output is assigned here, so each pin is a plain flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= StIdle;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_data <= 8'h00;
            sclk    <= 1'b0;
            cs_n    <= 1'b1;
            mosi    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        tx_sr   <= addr;
                        mosi    <= addr[7];
                        cs_n    <= 1'b0;
                        busy    <= 1'b1;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= StSetup;
                    end
                end

                StSetup: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        sclk    <= 1'b1;
                        state   <= StShift;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                StShift: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (sclk) begin
                            // End of high phase: sample MISO, then present the next MOSI bit.
                            // Zeros shift in behind the address, so bits 8-15 drive 0.
                            sclk  <= 1'b0;
                            tx_sr <= {tx_sr[6:0], 1'b0};
                            mosi  <= tx_sr[6];
                            if (bit_cnt[3]) begin
                                rx_sr <= {rx_sr[6:0], miso};
                            end
                        end else if (bit_cnt == 4'd15) begin
                            state <= StHold;
                        end else begin
                            sclk    <= 1'b1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                StHold: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        cs_n    <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rd_data <= rx_sr;
                        state   <= StFinish;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                // One dead cycle with cs_n high; start is ignored here.
                StFinish: begin
                    state <= StIdle;
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_rom_reader.sv
// Bench for spi_rom_reader: two instances (CLK_DIV=4 and CLK_DIV=1) against a
// behavioural ROM slave that answers addr+1 and moves MISO one cycle after SCLK falls.
module tb_spi_rom_reader;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       start_r = '0;
    logic [1:0]       miso_r = '0;
    logic [1:0][7:0]  addr_r = '0;
    logic [1:0]       sclk_w, cs_n_w, mosi_w, busy_w, done_w;
    logic [1:0][7:0]  rd_w;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_rom_reader #(.CLK_DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start_r[0]), .addr(addr_r[0]),
        .busy(busy_w[0]), .done(done_w[0]), .rd_data(rd_w[0]),
        .sclk(sclk_w[0]), .cs_n(cs_n_w[0]), .mosi(mosi_w[0]), .miso(miso_r[0])
    );

    spi_rom_reader #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_r[1]), .addr(addr_r[1]),
        .busy(busy_w[1]), .done(done_w[1]), .rd_data(rd_w[1]),
        .sclk(sclk_w[1]), .cs_n(cs_n_w[1]), .mosi(mosi_w[1]), .miso(miso_r[1])
    );

    // ---------------- behavioural ROM slave (one per DUT) ----------------
    int         rise_n[2]    = '{0, 0};
    int         fall_n[2]    = '{0, 0};
    int         tail_ones[2] = '{0, 0};
    logic [7:0] s_addr[2]    = '{8'h00, 8'h00};
    logic       pend[2]      = '{1'b0, 1'b0};
    logic       pend_v[2]    = '{1'b0, 1'b0};
    logic       prev_sclk[2] = '{1'b0, 1'b0};
    logic [7:0] rom_byte;

    // Slave reacts 1 time unit after each clk edge; MISO moves one cycle after SCLK falls.
    always @(posedge clk) begin
        #1;
        for (int g = 0; g < 2; g++) begin
            if (pend_v[g]) begin
                miso_r[g] = pend[g];
                pend_v[g] = 1'b0;
            end
            if (cs_n_w[g]) begin
                rise_n[g] = 0;
                fall_n[g] = 0;
            end else begin
                if (sclk_w[g] && !prev_sclk[g]) begin
                    if (rise_n[g] < 8) s_addr[g] = {s_addr[g][6:0], mosi_w[g]};
                    else if (mosi_w[g]) tail_ones[g]++;
                    rise_n[g]++;
                end
                if (!sclk_w[g] && prev_sclk[g]) begin
                    fall_n[g]++;
                    rom_byte = s_addr[g] + 8'd1;
                    // Data bit for rise k+1 is set up after fall k (k = 8..15); else noise.
                    if (fall_n[g] >= 8 && fall_n[g] <= 15) pend[g] = rom_byte[15 - fall_n[g]];
                    else pend[g] = 1'($urandom);
                    pend_v[g] = 1'b1;
                end
            end
            prev_sclk[g] = sclk_w[g];
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Issue one request at the next negedge (cycle 0) and observe until done.
    task automatic run_frame(input int g, input logic [7:0] a, output int done_c, output int csl,
                             output int rises, output int busy_bad, output int rd_moves,
                             output int tail);
        logic [7:0] rd0;
        logic       ps;
        int         t0;
        @(negedge clk);
        start_r[g] = 1'b1;
        addr_r[g]  = a;
        rd0 = rd_w[g];
        ps  = sclk_w[g];
        t0  = tail_ones[g];
        done_c = -1; csl = 0; rises = 0; busy_bad = 0; rd_moves = 0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start_r[g] = 1'b0;
                addr_r[g]  = ~a;  // must not disturb the frame in flight
            end
            if (!cs_n_w[g]) csl++;
            if (sclk_w[g] && !ps) rises++;
            ps = sclk_w[g];
            if (done_w[g]) begin
                done_c = c;
                break;
            end
            if (!busy_w[g]) busy_bad++;
            if (rd_w[g] !== rd0) rd_moves++;
        end
        tail = tail_ones[g] - t0;
    endtask

    task automatic run_vec(input int g, input logic [7:0] a, input logic [7:0] exp_rd,
                           input int exp_done, input int exp_csl);
        int dc, csl, rises, bb, rm, tail;
        run_frame(g, a, dc, csl, rises, bb, rm, tail);
        chk("done_cycle", dc, exp_done);
        chk("rd_data", rd_w[g], exp_rd);
        chk("busy_at_done", busy_w[g], 0);
        chk("cs_n_at_done", cs_n_w[g], 1);
        chk("cs_low_cycles", csl, exp_csl);
        chk("sclk_rises", rises, 16);
        chk("mosi_addr_bits", s_addr[g], a);
        chk("mosi_tail_zero", tail, 0);
        chk("busy_during", bb, 0);
        chk("rd_hold_in_frame", rm, 0);
        @(negedge clk);
        chk("done_pulse_width", done_w[g], 0);
        chk("rd_hold_after", rd_w[g], exp_rd);
    endtask

    typedef struct {
        int         g;
        logic [7:0] a;
        logic [7:0] exp_rd;
        int         exp_done;
        int         exp_csl;
    } vec_t;

    vec_t vt[5];

    initial begin
        int dl[$];
        int h;
        logic [7:0] a;
        int g;

        vt[0] = '{0, 8'h12, 8'h13, 137, 136};
        vt[1] = '{0, 8'hFF, 8'h00, 137, 136};
        vt[2] = '{0, 8'h00, 8'h01, 137, 136};
        vt[3] = '{1, 8'hA5, 8'hA6, 35, 34};
        vt[4] = '{0, 8'h7E, 8'h7F, 137, 136};

        // Reset values.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_cs_n", cs_n_w[i], 1);
            chk("rst_sclk", sclk_w[i], 0);
            chk("rst_mosi", mosi_w[i], 0);
            chk("rst_busy", busy_w[i], 0);
            chk("rst_done", done_w[i], 0);
            chk("rst_rd_data", rd_w[i], 0);
        end
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 5; i++) begin
            run_vec(vt[i].g, vt[i].a, vt[i].exp_rd, vt[i].exp_done, vt[i].exp_csl);
            repeat (3) @(negedge clk);
            chk("rd_hold_idle", rd_w[vt[i].g], vt[i].exp_rd);
        end

        // Start pulses at 0, 10, 137 (ignored) and 138 (accepted).
        for (int c = 0; c <= 400; c++) begin
            @(negedge clk);
            if (done_w[0]) dl.push_back(c);
            if (c == 137 || c == 138) chk("cs_n_gap", cs_n_w[0], 1);
            start_r[0] = (c == 0 || c == 10 || c == 137 || c == 138);
            addr_r[0]  = 8'h40;
            if (dl.size() == 2) break;
        end
        start_r[0] = 1'b0;
        chk("start_ignore_frames", dl.size(), 2);
        chk("start_ignore_done0", (dl.size() > 0) ? dl[0] : -1, 137);
        chk("start_ignore_done1", (dl.size() > 1) ? dl[1] : -1, 275);
        chk("start_ignore_rd", rd_w[0], 8'h41);

        // Reset in the middle of a frame.
        repeat (2) @(negedge clk);
        start_r[0] = 1'b1;
        addr_r[0]  = 8'h55;
        dl.delete();
        for (int c = 1; c <= 59; c++) begin
            @(negedge clk);
            if (done_w[0]) dl.push_back(c);
            if (c == 1) start_r[0] = 1'b0;
            if (c == 50) rst = 1'b1;
            if (c == 51) begin
                rst = 1'b0;
                chk("midrst_cs_n", cs_n_w[0], 1);
                chk("midrst_sclk", sclk_w[0], 0);
                chk("midrst_busy", busy_w[0], 0);
                chk("midrst_rd_data", rd_w[0], 0);
            end
        end
        chk("midrst_no_done", dl.size(), 0);
        run_vec(0, 8'h3C, 8'h3D, 137, 136);

        // Randomized frames against the ROM rule: data = addr+1, done at 34H+1.
        for (int i = 0; i < 16; i++) begin
            g = ($urandom_range(0, 3) == 0) ? 1 : 0;
            h = (g == 1) ? 1 : 4;
            a = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_vec(g, a, 8'(a + 8'd1), 34 * h + 1, 34 * h);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
